// File: rtl/gpio_cfg_pkg.sv
// Shared constants and loader state type for the GPIO configuration serial loader.
package gpio_cfg_pkg;

   localparam int CFG_WIDTH      = 13;
   localparam int GPIO_PER_CHAIN = 19;
   localparam int NUM_GPIO       = 2 * GPIO_PER_CHAIN;
   localparam int CHAIN_BITS     = GPIO_PER_CHAIN * CFG_WIDTH;
   localparam int CFG_BITS       = NUM_GPIO * CFG_WIDTH;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LOAD     = 2'd3
   } loader_state_t;

endpackage

// File: rtl/gpio_serial_tick.sv
// Phase timer: down-counter reloaded on every loader state entry; phase_end at terminal count.
module gpio_serial_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clear,
   output logic phase_end
);

   localparam logic [3:0] RELOAD = 4'(CLK_DIV - 1);

   logic [3:0] count;

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         count <= 4'd0;
      end else if (clear) begin
         count <= RELOAD;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign phase_end = (count == 4'd0);

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts the 38 GPIO configuration words into the two pad-ring control chains.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; serial data held at 0
//   SHIFT_LO | serial_clock low, current bit presented on both chains
//   SHIFT_HI | serial_clock high, chains capture; advance or finish
//   LOAD     | serial_load high, chain contents move to output registers
module gpio_serial_loader
   import gpio_cfg_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rstn_i,
   input  logic                start,
   input  logic [CFG_BITS-1:0] cfg_data,
   output logic                serial_clock,
   output logic                serial_load,
   output logic                serial_resetn,
   output logic                serial_data_1,
   output logic                serial_data_2,
   output logic                busy,
   output logic                done
);

   localparam logic [4:0] WORD_LAST = 5'(GPIO_PER_CHAIN - 1);
   localparam logic [3:0] BIT_FIRST = 4'(CFG_WIDTH - 1);

   loader_state_t state;
   loader_state_t state_next;

   logic [4:0]           word_cnt;
   logic [3:0]           bit_cnt;
   logic                 last_bit;
   logic                 phase_end;
   logic                 tick_clear;
   logic                 shifting;
   logic [5:0]           idx_1;
   logic [5:0]           idx_2;
   logic [CFG_WIDTH-1:0] word_1;
   logic [CFG_WIDTH-1:0] word_2;
   logic [CFG_WIDTH-1:0] shadow [NUM_GPIO];

   gpio_serial_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk_sys  (wb_clk_i),
      .rst_b    (wb_rstn_i),
      .clear    (tick_clear),
      .phase_end(phase_end)
   );

   assign last_bit = (word_cnt == WORD_LAST) && (bit_cnt == 4'd0);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start)     state_next = SHIFT_LO;
         SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
         SHIFT_HI: if (phase_end) state_next = last_bit ? LOAD : SHIFT_LO;
         LOAD:     if (phase_end) state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
      tick_clear = (state_next != state);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state         <= IDLE;
         word_cnt      <= 5'd0;
         bit_cnt       <= 4'd0;
         done          <= 1'b0;
         serial_resetn <= 1'b0;
      end else begin
         state         <= state_next;
         done          <= (state == LOAD) && phase_end;
         serial_resetn <= 1'b1;
         if ((state == IDLE) && start) begin
            word_cnt <= 5'd0;
            bit_cnt  <= BIT_FIRST;
         end else if ((state == SHIFT_HI) && phase_end && !last_bit) begin
            if (bit_cnt == 4'd0) begin
               bit_cnt  <= BIT_FIRST;
               word_cnt <= word_cnt + 5'd1;
            end else begin
               bit_cnt <= bit_cnt - 4'd1;
            end
         end
      end
   end

   // Snapshot so later cfg_data writes cannot disturb a transfer in flight.
   always_ff @(posedge wb_clk_i) begin
      if ((state == IDLE) && start) begin
         for (int i = 0; i < NUM_GPIO; i++) begin
            shadow[i] <= cfg_data[CFG_WIDTH*i +: CFG_WIDTH];
         end
      end
   end

   // Chain 1 walks GPIO 18 down to 0; chain 2 walks GPIO 19 up to 37.
   always_comb begin
      idx_1  = 6'(WORD_LAST - word_cnt);
      idx_2  = 6'(GPIO_PER_CHAIN) + 6'(word_cnt);
      word_1 = shadow[idx_1];
      word_2 = shadow[idx_2];
   end

   assign shifting      = (state == SHIFT_LO) || (state == SHIFT_HI);
   assign serial_clock  = (state == SHIFT_HI);
   assign serial_load   = (state == LOAD);
   assign busy          = (state != IDLE);
   assign serial_data_1 = shifting & word_1[bit_cnt];
   assign serial_data_2 = shifting & word_2[bit_cnt];

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Randomized scoreboard bench for gpio_serial_loader with modelled pad-ring chains.
module tb_gpio_serial_loader;
   import gpio_cfg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rstn;
   logic                start0, start1;
   logic [CFG_BITS-1:0] cfg0, cfg1;
   logic                sel;

   logic sclk0, load0, resetn0, da0, db0, busy0, done0;
   logic sclk1, load1, resetn1, da1, db1, busy1, done1;

   gpio_serial_loader #(.CLK_DIV(2)) u_dut (
      .wb_clk_i(clk), .wb_rstn_i(rstn), .start(start0), .cfg_data(cfg0),
      .serial_clock(sclk0), .serial_load(load0), .serial_resetn(resetn0),
      .serial_data_1(da0), .serial_data_2(db0), .busy(busy0), .done(done0));

   gpio_serial_loader #(.CLK_DIV(1)) u_dut_div1 (
      .wb_clk_i(clk), .wb_rstn_i(rstn), .start(start1), .cfg_data(cfg1),
      .serial_clock(sclk1), .serial_load(load1), .serial_resetn(resetn1),
      .serial_data_1(da1), .serial_data_2(db1), .busy(busy1), .done(done1));

   logic m_sclk, m_load, m_d1, m_d2, m_busy, m_done;
   assign m_sclk = sel ? sclk1 : sclk0;
   assign m_load = sel ? load1 : load0;
   assign m_d1   = sel ? da1   : da0;
   assign m_d2   = sel ? db1   : db0;
   assign m_busy = sel ? busy1 : busy0;
   assign m_done = sel ? done1 : done0;

   typedef struct {
      logic [CFG_BITS-1:0] cfg;
      int                  busy_len;
      int                  div;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor state
   int m_rises, m_busy_cnt, m_load_cyc, m_loads, m_stable_err, m_ones;
   int idle_err = 0, n_done = 0, last_ones = 0;
   logic load_seen = 1'b0;
   logic prev_sclk, prev_load, prev_d1, prev_d2, chk_done_low;
   logic [CHAIN_BITS-1:0] ch1, ch2, seq1, seq2, last_seq1, last_seq2;

   function automatic logic [CFG_WIDTH-1:0] cfg_word(logic [CFG_BITS-1:0] c, int g);
      return c[CFG_WIDTH*g +: CFG_WIDTH];
   endfunction

   function automatic logic [CFG_WIDTH-1:0] seq_word(logic [CHAIN_BITS-1:0] s, int first);
      logic [CFG_WIDTH-1:0] w = '0;
      for (int b = 0; b < CFG_WIDTH; b++) w = {w[CFG_WIDTH-2:0], s[first+b]};
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rstn) begin
         m_rises = 0; m_busy_cnt = 0; m_load_cyc = 0; m_loads = 0;
         m_stable_err = 0; m_ones = 0; chk_done_low = 1'b0;
         prev_sclk = 1'b0; prev_load = 1'b0; prev_d1 = 1'b0; prev_d2 = 1'b0;
         ch1 = '0; ch2 = '0; seq1 = '0; seq2 = '0;
      end else begin
         if (chk_done_low) begin
            check("done_width", m_done, 1'b0);
            chk_done_low = 1'b0;
         end
         if (m_busy) m_busy_cnt++;
         if (!m_busy && (m_d1 || m_d2 || m_sclk || m_load)) idle_err++;
         if (m_load && (m_d1 || m_d2)) idle_err++;
         if (m_sclk && prev_sclk && ((m_d1 != prev_d1) || (m_d2 != prev_d2))) m_stable_err++;
         if (m_sclk && !prev_sclk) begin
            ch1 = {ch1[CHAIN_BITS-2:0], m_d1};
            ch2 = {ch2[CHAIN_BITS-2:0], m_d2};
            if (m_rises < CHAIN_BITS) begin
               seq1[m_rises] = m_d1;
               seq2[m_rises] = m_d2;
            end
            if (m_d1 && m_d2) m_ones++;
            m_rises++;
         end
         if (m_load) begin
            m_load_cyc++;
            load_seen = 1'b1;
         end
         if (m_load && !prev_load) m_loads++;
         if (m_done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1'b1, 1'b0);
            end else begin
               exp_t e;
               logic [CHAIN_BITS-1:0] x1, x2;
               e = sb.pop_front();
               // Chain 1: GPIO g sits at [13g]; chain 2: GPIO 37 is nearest the entry point.
               for (int g = 0; g < GPIO_PER_CHAIN; g++) begin
                  x1[CFG_WIDTH*g +: CFG_WIDTH] = cfg_word(e.cfg, g);
                  x2[CFG_WIDTH*(GPIO_PER_CHAIN-1-g) +: CFG_WIDTH] = cfg_word(e.cfg, GPIO_PER_CHAIN + g);
               end
               check("busy_cycles", m_busy_cnt, e.busy_len);
               check("clock_rises", m_rises, CHAIN_BITS);
               check("load_pulses", m_loads, 1);
               check("load_cycles", m_load_cyc, e.div);
               check("data_stable", m_stable_err, 0);
               check("chain1", ch1, x1);
               check("chain2", ch2, x2);
            end
            last_seq1 = seq1; last_seq2 = seq2; last_ones = m_ones;
            m_rises = 0; m_busy_cnt = 0; m_load_cyc = 0; m_loads = 0;
            m_stable_err = 0; m_ones = 0;
            n_done++;
            chk_done_low = 1'b1;
         end
         prev_sclk = m_sclk; prev_load = m_load; prev_d1 = m_d1; prev_d2 = m_d2;
      end
   end

   task automatic launch();
      exp_t e;
      e.div      = sel ? 1 : 2;
      e.busy_len = 2 * e.div * CHAIN_BITS + e.div;
      e.cfg      = sel ? cfg1 : cfg0;
      sb.push_back(e);
      load_seen = 1'b0;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_drain(int limit);
      int n = 0;
      while ((sb.size() != 0) && (n < limit)) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         check("timeout", 1'b1, 1'b0);
         sb.delete();
      end
      tick();
   endtask

   task automatic fill_random(output logic [CFG_BITS-1:0] c);
      for (int i = 0; i < NUM_GPIO; i++) c[CFG_WIDTH*i +: CFG_WIDTH] = CFG_WIDTH'($urandom);
   endtask

   initial begin
      int err;
      int dn;
      rstn = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
      cfg0 = '0; cfg1 = '0;
      repeat (3) tick();
      check("reset_outputs", {sclk0, load0, resetn0, da0, db0, busy0, done0}, 7'd0);
      rstn = 1'b1;
      tick();
      check("resetn_rise", {resetn0, resetn1}, 2'b11);
      err = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (sclk0 || load0 || busy0 || done0 || sclk1 || load1 || busy1 || done1) err++;
      end
      check("idle_quiet", err, 0);

      // Pattern load at defaults
      for (int i = 0; i < NUM_GPIO; i++) cfg0[CFG_WIDTH*i +: CFG_WIDTH] = CFG_WIDTH'(13'h1000 | i);
      launch();
      wait_drain(3000);
      check("first_word_1", seq_word(last_seq1, 0), 13'h1012);
      check("first_word_2", seq_word(last_seq2, 0), 13'h1013);
      check("last_word_1", seq_word(last_seq1, CHAIN_BITS - CFG_WIDTH), 13'h1000);
      check("last_word_2", seq_word(last_seq2, CHAIN_BITS - CFG_WIDTH), 13'h1025);

      // Random words, including a back-to-back start on the done cycle
      fill_random(cfg0);
      launch();
      while (!done0) tick();
      fill_random(cfg0);
      launch();
      wait_drain(3000);

      // start during busy is ignored
      fill_random(cfg0);
      dn = n_done;
      launch();
      repeat (400) tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_drain(3000);
      repeat (1100) tick();
      check("single_done", n_done - dn, 1);
      check("no_restart", busy0, 1'b0);

      // cfg_data changes after start have no effect
      fill_random(cfg0);
      launch();
      repeat (10) tick();
      fill_random(cfg0);
      wait_drain(3000);

      // CLK_DIV=1 instance, all ones
      sel = 1'b1;
      tick();
      for (int i = 0; i < NUM_GPIO; i++) cfg1[CFG_WIDTH*i +: CFG_WIDTH] = 13'h1FFF;
      launch();
      wait_drain(2000);
      check("all_ones", last_ones, CHAIN_BITS);
      fill_random(cfg1);
      launch();
      wait_drain(2000);
      sel = 1'b0;
      tick();

      // Reset in the middle of a transfer
      fill_random(cfg0);
      launch();
      repeat (500) tick();
      rstn = 1'b0;
      tick();
      check("abort_outputs", {sclk0, load0, resetn0, da0, db0, busy0, done0}, 7'd0);
      check("abort_no_load", load_seen, 1'b0);
      sb.delete();
      rstn = 1'b1;
      tick();
      fill_random(cfg0);
      launch();
      wait_drain(3000);

      check("idle_data_zero", idle_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
